vga_layer_mux: RTL and testbench
================================

Name: vga_layer_mux

Overview:
- Per-pixel compositor and scheduler in front of the 5-bit-to-RGB colour decoder.
- Takes one 5-bit colour code per overlay layer (grid, traces, cursors, text) and selects the highest-priority visible layer. Supports per-layer enable, frame-synchronous blinking and a programmable background.
- Emits one 5-bit code plus a pixel-valid to the decoder through a fixed 2-cycle pipeline.
- Configuration is written via a simple handshake and applied only at frame boundaries, to avoid tearing.

Parameters:
- NUM_LAYERS, 4, number of overlay layers; layer 0 has highest priority; legal range 1..8.
- CNT_W, 20, width of the optional opaque-pixel statistics counter.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; asynchronous assert, active-low
- frame_start  in  1  single-cycle pulse at the first pixel of each frame
- pix_valid_in  in  1  layer codes valid this cycle
- layer_cidx  in  5*NUM_LAYERS  layer n occupies bits [5n+4:5n]
- cfg_wr  in  1  configuration write strobe
- cfg_addr  in  2  register select
- cfg_wdata  in  8  write data
- cfg_ack  out  1  one-cycle acknowledge
- pix_valid_out  out  1  output code valid
- cout_idx  out  5  selected colour code, to the colour decoder
- cout_layer  out  3  winning layer index; value NUM_LAYERS means background
- stat_opaque_cnt  out  CNT_W  opaque pixel count for the previous frame (optional feature)

Behaviour:
- Reset values: all outputs 0. Pipeline valids cleared. Shadow and active registers take these values:
  - EN = all ones
  - BLINK = 0
  - BG = 5'b00000
  - PERIOD = 0
- Blink phase resets to 1 (visible). Frame counter resets to 0. Reset mid-frame drops in-flight pixels.
- Registers (addr: name, bits used):
  - 0: EN, [NUM_LAYERS-1:0]
  - 1: BLINK, [NUM_LAYERS-1:0]
  - 2: BG, [4:0]
  - 3: PERIOD, [7:0], in frames
  - Unused bits are ignored.
- Config state machine:
  - IDLE: on cfg_wr, write the shadow register, assert cfg_ack in the next cycle only, go to PENDING.
  - PENDING: further writes still update shadow registers and are acked the same way. On frame_start, copy all shadow registers to active and return to IDLE.
  - cfg_wr coincident with frame_start in PENDING: the coincident write lands in shadow only. It is not in this copy. The state stays PENDING and the write applies at the next frame_start.
  - cfg_wr coincident with frame_start in IDLE: goes to PENDING; not applied this frame.
- Blink:
  - On each frame_start, if active PERIOD == 0, hold phase = 1 and counter = 0.
  - Otherwise, when counter == PERIOD-1, set counter = 0 and toggle phase; else increment counter.
  - A layer is visible iff EN[n] & (~BLINK[n] | phase).
- Stage 1 (cycle 1): register layer_cidx, pix_valid_in and the per-layer visible vector, using active registers sampled in the same cycle.
- Stage 2 (cycle 2):
  - Pick the lowest n where visible[n] and code != 5'b11000 (transparent key).
  - If none qualifies, output BG and set cout_layer = NUM_LAYERS.
  - Register cout_idx, cout_layer and pix_valid_out.
- Latency is exactly 2 cycles from pix_valid_in to pix_valid_out. Throughput is 1 pixel per cycle with no back-pressure.
- When pix_valid_in = 0, the pipeline propagates valid = 0 and the data outputs hold their previous values.
- BG may be 5'b11000; it is then passed through so the decoder masks the pixel.
- frame_start arriving with a pixel in the pipeline: the pixel is not affected. New active values apply from the pixel sampled in that frame_start cycle onward.

Optional Feature:
- Macro VGA_LAYER_STATS_EN.
- Defined:
  - Counter increments on each pix_valid_out cycle with cout_idx != 5'b11000, and saturates at all ones.
  - On frame_start, the count is copied to stat_opaque_cnt and the counter cleared. A pixel counted in the same cycle goes into the new frame's count.
- Undefined: stat_opaque_cnt is tied to 0 and no counter logic exists.

Decomposition:
- Shared package vga_pkg holds:
  - the colour-code constants (transparent key 5'b11000, black 5'b00000, white 5'b00111)
  - the register address constants CFG_EN, CFG_BLINK, CFG_BG, CFG_PERIOD
  - the config state enum IDLE/PENDING
- Sub-module vga_blink_timer contains the frame counter and phase logic, with inputs frame_start and PERIOD and output phase.
- The priority selector stays inline.

Test Plan:
- After reset, layers = {L3 00001, L2 00010, L1 11000, L0 11000} with valid: 2 cycles later cout_idx = 00010, cout_layer = 2, pix_valid_out = 1.
- All layers 11000 with BG written 5'b01000 and a frame_start then sent: output 01000 with cout_layer = 4. Before the frame_start, output stays 00000.
- Write EN = 4'b1110 mid-frame: cfg_ack pulses once and L0 00001 still wins until frame_start. After frame_start the next visible layer wins.
- PERIOD = 2, BLINK = 4'b0001, L0 = 00100, L1 = 00001, 8 frame_starts: L0 visible in frames 0-1, hidden in frames 2-3 (output 00001), visible again in frames 4-5.
- cfg_wr BG = 00111 in the same cycle as frame_start: not applied at that frame. Applied at the following frame_start.
- With VGA_LAYER_STATS_EN: 100 valid opaque pixels and 20 transparent pixels, then frame_start: stat_opaque_cnt = 100. Reset asserted mid-frame: pix_valid_out drops to 0 immediately and the counter clears.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA layer compositor.
// Holds the colour-code constants, the configuration register map and the
// configuration state type used by vga_layer_mux and its sub-modules.
package vga_pkg;

  localparam logic [4:0] CIDX_TRANSPARENT = 5'b11000;
  localparam logic [4:0] CIDX_BLACK       = 5'b00000;
  localparam logic [4:0] CIDX_WHITE       = 5'b00111;

  localparam logic [1:0] CFG_EN     = 2'd0;
  localparam logic [1:0] CFG_BLINK  = 2'd1;
  localparam logic [1:0] CFG_BG     = 2'd2;
  localparam logic [1:0] CFG_PERIOD = 2'd3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

endpackage

// File: rtl/vga_blink_timer.sv
// Frame-synchronous blink phase generator.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   frame_start  one-cycle pulse at the first pixel of each frame
//   period       active blink half-period in frames (0 = never blink)
//   phase        blink phase in effect for the current cycle (1 = visible)
// The counter advances on each frame_start using the period that was active
// before that frame_start.  The phase output already reflects the update made
// on the frame_start cycle, so the first pixel of a frame sees the new phase.
module vga_blink_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [7:0] period,
  output logic       phase
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       phase_q;
  logic       phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (period == '0) begin
        cnt_d   = '0;
        phase_d = 1'b1;
      end else if (cnt_q == period - 8'd1) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule

// File: rtl/vga_layer_mux.sv
// Per-pixel overlay compositor in front of the 5-bit colour decoder.
// Selects the highest-priority visible, non-transparent layer (layer 0 first)
// through a fixed 2-stage pipeline; falls back to the background code.
// Configuration writes land in shadow registers and are copied to the active
// set on frame_start.
// Optional feature: define VGA_LAYER_STATS_EN to enable the per-frame
// opaque-pixel counter on stat_opaque_cnt (tied to 0 otherwise).
// Ports:
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   frame_start      first-pixel-of-frame pulse
//   pix_valid_in     layer codes valid this cycle
//   layer_cidx       layer n code in bits [5n+4:5n]
//   cfg_wr/addr/wdata configuration write port, cfg_ack one-cycle acknowledge
//   pix_valid_out    output code valid (2 cycles after pix_valid_in)
//   cout_idx         selected colour code
//   cout_layer       winning layer, NUM_LAYERS for background
//   stat_opaque_cnt  opaque pixel count of the previous frame
module vga_layer_mux #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    pix_valid_in,
  input  logic [5*NUM_LAYERS-1:0] layer_cidx,
  input  logic                    cfg_wr,
  input  logic [1:0]              cfg_addr,
  input  logic [7:0]              cfg_wdata,
  output logic                    cfg_ack,
  output logic                    pix_valid_out,
  output logic [4:0]              cout_idx,
  output logic [2:0]              cout_layer,
  output logic [CNT_W-1:0]        stat_opaque_cnt
);

  import vga_pkg::*;

  // With NUM_LAYERS = 8 the background index wraps to 0 in the 3-bit field.
  localparam logic [2:0] LAYER_BG = 3'(NUM_LAYERS);

  cfg_state_t              state_q;
  logic [NUM_LAYERS-1:0]   sh_en, sh_blink, act_en, act_blink;
  logic [4:0]              sh_bg, act_bg;
  logic [7:0]              sh_period, act_period;

  logic                    apply;
  logic [NUM_LAYERS-1:0]   eff_en, eff_blink, visible;
  logic [4:0]              eff_bg;
  logic                    phase;

  logic                    s1_valid;
  logic [5*NUM_LAYERS-1:0] s1_cidx;
  logic [NUM_LAYERS-1:0]   s1_vis;
  logic [4:0]              s1_bg;

  logic [4:0]              sel_idx;
  logic [2:0]              sel_layer;
  logic                    found;

  // A pending update lands on frame_start; the pixel sampled in that same
  // cycle must already see the new values, so bypass the shadow set.
  assign apply     = frame_start && (state_q == PENDING);
  assign eff_en    = apply ? sh_en    : act_en;
  assign eff_blink = apply ? sh_blink : act_blink;
  assign eff_bg    = apply ? sh_bg    : act_bg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cfg_ack    <= 1'b0;
      sh_en      <= '1;
      sh_blink   <= '0;
      sh_bg      <= CIDX_BLACK;
      sh_period  <= '0;
      act_en     <= '1;
      act_blink  <= '0;
      act_bg     <= CIDX_BLACK;
      act_period <= '0;
    end else begin
      cfg_ack <= cfg_wr;
      // The copy reads the shadow values before any coincident write lands.
      if (apply) begin
        act_en     <= sh_en;
        act_blink  <= sh_blink;
        act_bg     <= sh_bg;
        act_period <= sh_period;
      end
      if (cfg_wr) begin
        case (cfg_addr)
          CFG_EN:     sh_en     <= cfg_wdata[NUM_LAYERS-1:0];
          CFG_BLINK:  sh_blink  <= cfg_wdata[NUM_LAYERS-1:0];
          CFG_BG:     sh_bg     <= cfg_wdata[4:0];
          CFG_PERIOD: sh_period <= cfg_wdata;
          default:    ;
        endcase
      end
      case (state_q)
        IDLE:    if (cfg_wr) state_q <= PENDING;
        PENDING: if (frame_start && !cfg_wr) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  vga_blink_timer u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .period      (act_period),
    .phase       (phase)
  );

  assign visible = eff_en & (~eff_blink | {NUM_LAYERS{phase}});

  // Stage 1: capture codes with their visibility and background.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cidx  <= '0;
      s1_vis   <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      if (pix_valid_in) begin
        s1_cidx <= layer_cidx;
        s1_vis  <= visible;
        s1_bg   <= eff_bg;
      end
    end
  end

  // Stage 2: priority select, lowest layer index wins.
  always_comb begin
    sel_idx   = s1_bg;
    sel_layer = LAYER_BG;
    found     = 1'b0;
    for (int unsigned n = 0; n < NUM_LAYERS; n++) begin
      if (!found && s1_vis[n] && (s1_cidx[5*n +: 5] != CIDX_TRANSPARENT)) begin
        found     = 1'b1;
        sel_idx   = s1_cidx[5*n +: 5];
        sel_layer = 3'(n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_out <= 1'b0;
      cout_idx      <= '0;
      cout_layer    <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        cout_idx   <= sel_idx;
        cout_layer <= sel_layer;
      end
    end
  end

`ifdef VGA_LAYER_STATS_EN
  logic [CNT_W-1:0] opq_cnt;
  logic             count_now;

  assign count_now = pix_valid_out && (cout_idx != CIDX_TRANSPARENT);

  // A pixel counted on the frame_start cycle belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opq_cnt         <= '0;
      stat_opaque_cnt <= '0;
    end else if (frame_start) begin
      stat_opaque_cnt <= opq_cnt;
      opq_cnt         <= CNT_W'(count_now);
    end else if (count_now && (opq_cnt != '1)) begin
      opq_cnt <= opq_cnt + 1'b1;
    end
  end
`else
  assign stat_opaque_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_layer_mux.sv
// Randomised scoreboard bench for vga_layer_mux (NUM_LAYERS = 4).
module tb_vga_layer_mux;

  localparam int NL    = 4;
  localparam int CW    = 20;
  localparam int TRANS = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid_in = 1'b0;
  logic [5*NL-1:0] layer_cidx = '0;
  logic          cfg_wr = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [7:0]    cfg_wdata = '0;
  logic          cfg_ack;
  logic          pix_valid_out;
  logic [4:0]    cout_idx;
  logic [2:0]    cout_layer;
  logic [CW-1:0] stat_opaque_cnt;

  vga_layer_mux #(.NUM_LAYERS(NL), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .frame_start     (frame_start),
    .pix_valid_in    (pix_valid_in),
    .layer_cidx      (layer_cidx),
    .cfg_wr          (cfg_wr),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .cfg_ack         (cfg_ack),
    .pix_valid_out   (pix_valid_out),
    .cout_idx        (cout_idx),
    .cout_layer      (cout_layer),
    .stat_opaque_cnt (stat_opaque_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [4:0] idx;
    logic [2:0] layer;
  } exp_t;

  exp_t sbq[$];

  // registers: 0 EN, 1 BLINK, 2 BG, 3 PERIOD
  int m_sh[4];
  int m_act[4];
  bit m_pend;
  int m_fcnt;
  bit m_phase;
  bit last_wr;
  int last_idx, last_layer;
  int m_opq, m_stat;

  task automatic model_reset();
    m_sh  = '{15, 0, 0, 0};
    m_act = '{15, 0, 0, 0};
    m_pend = 0; m_fcnt = 0; m_phase = 1;
    last_wr = 0; last_idx = 0; last_layer = 0;
    m_opq = 0; m_stat = 0;
    sbq.delete();
  endtask

  task automatic model_step(input bit fs, input bit wr, input int a, input int d,
                            input bit pv, input logic [5*NL-1:0] cx);
    bit   upd;
    int   en, bl, bg, code;
    exp_t e;
    upd = fs && m_pend;
    if (fs) begin
      // blink period from the configuration in force before this boundary
      if (m_act[3] == 0) begin m_fcnt = 0; m_phase = 1; end
      else if (m_fcnt == m_act[3] - 1) begin m_fcnt = 0; m_phase = !m_phase; end
      else m_fcnt = (m_fcnt + 1) % 256;
    end
    en = upd ? m_sh[0] : m_act[0];
    bl = upd ? m_sh[1] : m_act[1];
    bg = upd ? m_sh[2] : m_act[2];
    if (pv) begin
      e.cyc = cyc; e.idx = 5'(bg); e.layer = 3'(NL);
      for (int n = NL - 1; n >= 0; n--) begin
        code = int'(cx[5*n +: 5]);
        if (en[n] && (!bl[n] || m_phase) && code != TRANS) begin
          e.idx = 5'(code); e.layer = 3'(n);
        end
      end
      sbq.push_back(e);
    end
    if (upd) m_act = m_sh;
    if (wr) begin
      case (a)
        0, 1: m_sh[a] = d % (1 << NL);
        2:    m_sh[a] = d % 32;
        default: m_sh[a] = d % 256;
      endcase
    end
    m_pend = wr || (m_pend && !fs);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      int   opq_now;
      opq_now = 0;
      check("cfg_ack", int'(cfg_ack), int'(last_wr));
      if (pix_valid_out) begin
        if (sbq.size() == 0) begin
          check("spurious_valid", int'(pix_valid_out), 0);
        end else begin
          e = sbq.pop_front();
          check("latency", cyc - e.cyc, 2);
          check("cout_idx", int'(cout_idx), int'(e.idx));
          check("cout_layer", int'(cout_layer), int'(e.layer));
          last_idx = int'(e.idx); last_layer = int'(e.layer);
          opq_now = (int'(e.idx) != TRANS) ? 1 : 0;
        end
      end else begin
        if (sbq.size() > 0 && sbq[0].cyc + 2 <= cyc) begin
          check("missing_valid", int'(pix_valid_out), 1);
          void'(sbq.pop_front());
        end
        check("hold_idx", int'(cout_idx), last_idx);
        check("hold_layer", int'(cout_layer), last_layer);
      end
      check("stat_opaque_cnt", int'(stat_opaque_cnt), m_stat);
`ifdef VGA_LAYER_STATS_EN
      if (frame_start) begin
        m_stat = m_opq;
        m_opq  = opq_now;
      end else if (m_opq + opq_now <= (1 << CW) - 1) begin
        m_opq = m_opq + opq_now;
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit fs, input bit wr, input int a, input int d,
                       input bit pv, input logic [5*NL-1:0] cx);
    @(posedge clk); #1;
    last_wr      = cfg_wr;
    frame_start  = fs;
    cfg_wr       = wr;
    cfg_addr     = 2'(a);
    cfg_wdata    = 8'(d);
    pix_valid_in = pv;
    layer_cidx   = pv ? cx : $urandom();
    model_step(fs, wr, a, d, pv, cx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, '0);
  endtask

  task automatic pix(input logic [5*NL-1:0] cx);
    drive(0, 0, 0, 0, 1, cx);
  endtask

  task automatic wr_reg(input int a, input int d);
    drive(0, 1, a, d, 0, '0);
  endtask

  task automatic fs_pix(input logic [5*NL-1:0] cx);
    drive(1, 0, 0, 0, 1, cx);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    frame_start = 0; cfg_wr = 0; pix_valid_in = 0; cfg_addr = '0; cfg_wdata = '0;
    #1;
    check("rst_valid", int'(pix_valid_out), 0);
    check("rst_idx", int'(cout_idx), 0);
    check("rst_layer", int'(cout_layer), 0);
    check("rst_ack", int'(cfg_ack), 0);
    check("rst_stat", int'(stat_opaque_cnt), 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [5*NL-1:0] pack4(input logic [4:0] l3, input logic [4:0] l2,
                                            input logic [4:0] l1, input logic [4:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  logic [5*NL-1:0] all_t;

  initial begin
    all_t = pack4(5'd24, 5'd24, 5'd24, 5'd24);
    model_reset();
    do_reset();

    // first pixel after reset: layer 2 wins
    pix(pack4(5'b00001, 5'b00010, 5'b11000, 5'b11000));
    idle(3);

    // background change held until frame_start
    wr_reg(2, 8'b01000);
    pix(all_t); pix(all_t);
    fs_pix(all_t);
    pix(all_t); idle(3);

    // EN written mid-frame; layer 0 keeps winning until the boundary
    pix(pack4(5'd5, 5'd6, 5'd7, 5'd1));
    wr_reg(0, 8'b1110);
    for (int i = 0; i < 3; i++) pix(pack4(5'd5, 5'd6, 5'd7, 5'd1));
    fs_pix(pack4(5'd5, 5'd6, 5'd7, 5'd1));
    pix(pack4(5'd5, 5'd6, 5'd7, 5'd1)); idle(3);

    // blink with a 2-frame half period on layer 0
    wr_reg(3, 2); wr_reg(1, 1); wr_reg(0, 8'hff);
    fs_pix(pack4(5'd24, 5'd24, 5'd1, 5'd4));
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 3; i++) pix(pack4(5'd24, 5'd24, 5'd1, 5'd4));
      fs_pix(pack4(5'd24, 5'd24, 5'd1, 5'd4));
    end
    idle(3);

    // write coincident with frame_start is deferred one frame
    drive(1, 1, 2, 8'b00111, 1, all_t);
    pix(all_t); pix(all_t);
    fs_pix(all_t);
    pix(all_t); idle(3);

    // opaque statistics: 100 opaque then 20 transparent pixels
    do_reset();
    wr_reg(2, TRANS);
    fs_pix(all_t);
    for (int i = 0; i < 100; i++)
      pix(pack4(5'd24, 5'd24, 5'd24, 5'($urandom_range(0, 23))));
    for (int i = 0; i < 20; i++) pix(all_t);
    idle(3);
    drive(1, 0, 0, 0, 0, '0);
    idle(3);
    drive(1, 0, 0, 0, 0, '0);
    idle(2);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit              fs, w, pv;
      int              a, d;
      logic [5*NL-1:0] cx;
      fs = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 7) == 0);
      pv = ($urandom_range(0, 3) != 0);
      a  = $urandom_range(0, 3);
      d  = (a == 3) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      for (int n = 0; n < NL; n++)
        cx[5*n +: 5] = ($urandom_range(0, 2) == 0) ? 5'd24 : 5'($urandom_range(0, 31));
      drive(fs, w, a, d, pv, cx);
    end
    idle(3);

    // reset with pixels in flight
    pix(pack4(5'd3, 5'd3, 5'd3, 5'd3));
    pix(pack4(5'd3, 5'd3, 5'd3, 5'd3));
    do_reset();
    fs_pix(pack4(5'd9, 5'd9, 5'd9, 5'd9));
    pix(pack4(5'd9, 5'd9, 5'd9, 5'd9));
    idle(3);
    drive(1, 0, 0, 0, 0, '0);
    idle(4);

    check("drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
